// File: rtl/pipe_ctrl_mi.sv
// Pipeline stall/flush controller for the multi-issue in-order core: per-stage holds,
// per-boundary bubbles, lane restart index, fence-drain / WFI-sleep tracking and stall watchdog.
module pipe_ctrl_mi #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned STAGES = 5,
  parameter int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
  parameter int unsigned WDOG_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_stall_req,
  input  logic              dcache_stall_req,
  input  logic              hazard_stall_req,
  input  logic              ex_stall_req,
  input  logic [LANES-1:0]  lane_wfi,
  input  logic [LANES-1:0]  lane_fence,
  input  logic [LANES-1:0]  ex_ldst,
  input  logic [LANES-1:0]  mem_ldst,
  input  logic [LANES-1:0]  ex_branch,
  input  logic [LANES-1:0]  dec_16bit,
  input  logic              csr_excp,
  input  logic              csr_wfi_clr,
  output logic [STAGES-1:0] ctrl_stall,
  output logic [STAGES-2:0] flush,
  output logic [LANE_W-1:0] issue_sel,
  output logic              wfi_active,
  output logic              wdog_timeout
);

  typedef enum logic [1:0] {
    StRun,
    StFenceDrain,
    StWfiSleep
  } state_e;

  state_e            state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_timeout_q, wdog_timeout_d;
  logic              wfi_active_q;

  logic any_wfi, any_fence, any_ex_ldst, any_mem_ldst, any_branch, any_dec16;

  assign any_wfi      = |lane_wfi;
  assign any_fence    = |lane_fence;
  assign any_ex_ldst  = |ex_ldst;
  assign any_mem_ldst = |mem_ldst;
  assign any_branch   = |ex_branch;
  assign any_dec16    = |dec_16bit;

  // Next state; WFI entry is checked before fence entry so it wins when both are present.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (any_wfi && !csr_wfi_clr && !csr_excp) begin
          state_d = StWfiSleep;
        end else if (any_fence && (any_ex_ldst || any_mem_ldst)) begin
          state_d = StFenceDrain;
        end
      end
      StFenceDrain: begin
        if (csr_excp || (!any_ex_ldst && !any_mem_ldst && !dcache_stall_req)) begin
          state_d = StRun;
        end
      end
      StWfiSleep: begin
        if (csr_wfi_clr || csr_excp) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Stall depth counted from IF; decisions use the state the core is in this cycle after
  // any entry/exit, so a WFI or fence takes hold in the cycle it is decoded.
  int unsigned       stall_len;
  logic [STAGES-1:0] stall_mask;

  always_comb begin
    stall_len = 0;
    if (state_d == StWfiSleep) begin
      stall_len = STAGES;
    end else if (csr_excp || any_branch) begin
      stall_len = 0;
    end else if (hazard_stall_req) begin
      stall_len = 2;
    end else if (dcache_stall_req || ((state_d == StFenceDrain) && any_mem_ldst)) begin
      stall_len = 3;
    end else if (state_d == StFenceDrain) begin
      stall_len = 2;
    end else if (icache_stall_req) begin
      stall_len = 1;
    end else if (ex_stall_req) begin
      stall_len = 3;
    end
    if (stall_len > STAGES) begin
      stall_len = STAGES;
    end
  end

  always_comb begin
    stall_mask = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      stall_mask[i] = (i < stall_len);
    end
  end

  // Lowest-index asserted lane for branch and realign redirects.
  int br_idx, dec_idx;

  always_comb begin
    br_idx  = 0;
    dec_idx = 0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (ex_branch[i]) br_idx = i;
      if (dec_16bit[i]) dec_idx = i;
    end
  end

  // Redirect vector is wide enough for bits 0..2 regardless of STAGES, then truncated.
  logic [STAGES+1:0] redir;
  logic [STAGES-2:0] bubble;
  logic [LANE_W-1:0] sel_comb;

  always_comb begin
    redir    = '0;
    sel_comb = '0;
    if (csr_excp) begin
      redir[2:0] = 3'b111;
    end else if (any_branch) begin
      redir[1:0] = 2'b11;
      redir[2]   = (br_idx < int'(LANES) - 1);
    end else if (any_dec16) begin
      redir[0] = 1'b1;
      redir[1] = (dec_idx < int'(LANES) - 1);
      sel_comb = LANE_W'((dec_idx + 1) % int'(LANES));
    end
  end

  always_comb begin
    bubble = '0;
    for (int unsigned i = 0; i < STAGES - 1; i++) begin
      bubble[i] = (stall_len > 0) && (stall_len < STAGES) && (i == stall_len - 1);
    end
  end

  // Watchdog ignores sleep; it saturates and flags only on the transition to all ones.
  always_comb begin
    if (stall_len == 0 || state_d == StWfiSleep) begin
      wdog_d = '0;
    end else if (wdog_q != '1) begin
      wdog_d = wdog_q + 1'b1;
    end else begin
      wdog_d = wdog_q;
    end
    wdog_timeout_d = (wdog_q != '1) && (wdog_d == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      wdog_q         <= '0;
      wdog_timeout_q <= 1'b0;
      wfi_active_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wdog_q         <= wdog_d;
      wdog_timeout_q <= wdog_timeout_d;
      wfi_active_q   <= (state_d == StWfiSleep);
    end
  end

  assign ctrl_stall   = rst ? '0 : stall_mask;
  assign flush        = rst ? '1 : (bubble | redir[STAGES-2:0]);
  assign issue_sel    = rst ? '0 : sel_comb;
  assign wfi_active   = !rst && wfi_active_q;
  assign wdog_timeout = !rst && wdog_timeout_q;

endmodule

// File: doc/pipe_ctrl_mi.md
Name: pipe_ctrl_mi

Overview:
Parametrised pipeline controller for the multi-issue in-order core. It generalises stall/flush generation to LANES issue lanes and STAGES pipeline stages. It adds registered fence-drain and WFI-sleep state tracking and a stall watchdog. It sits beside the IF/ID/EX/MEM/WB pipeline registers and drives their stall/flush enables and the issue-lane restart index.

Parameters:
LANES, 2, number of issue lanes (>=1); lane 0 is oldest
STAGES, 5, pipeline stages; stall bit i = stage i (0=IF); flush bit i = boundary i->i+1
LANE_W, $clog2(LANES) min 1, width of issue_sel
WDOG_W, 16, width of stall watchdog counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
icache_stall_req  in  1  I-cache miss
dcache_stall_req  in  1  D-cache miss
hazard_stall_req  in  1  decode load-use hazard
ex_stall_req  in  1  multi-cycle EX op busy
lane_wfi  in  LANES  decode lane holds WFI
lane_fence  in  LANES  decode lane holds FENCE
ex_ldst  in  LANES  EX lane holds load/store
mem_ldst  in  LANES  MEM lane holds load/store
ex_branch  in  LANES  EX lane redirect taken
dec_16bit  in  LANES  decode lane is compressed, realign needed
csr_excp  in  1  exception/interrupt redirect
csr_wfi_clr  in  1  wake event for WFI
ctrl_stall  out  STAGES  per-stage hold
flush  out  STAGES-1  per-boundary bubble insert
issue_sel  out  LANE_W  lane index at which the next issue group starts
wfi_active  out  1  core sleeping
wdog_timeout  out  1  one-cycle pulse, stall exceeded 2^WDOG_W-1 cycles

Behaviour:
- FSM states: RUN, FENCE_DRAIN, WFI_SLEEP; registered and reset to RUN.
- While rst=1: ctrl_stall=0, flush=all ones, issue_sel=0, wfi_active=0, wdog_timeout=0, watchdog=0. All outputs are forced regardless of inputs.
- RUN->WFI_SLEEP when any lane_wfi=1, csr_wfi_clr=0 and csr_excp=0. WFI_SLEEP->RUN on csr_wfi_clr or csr_excp.
- RUN->FENCE_DRAIN when any lane_fence=1 and any ex_ldst or mem_ldst=1. FENCE_DRAIN->RUN in the first cycle with ex_ldst=0, mem_ldst=0 and dcache_stall_req=0, or on csr_excp (abort).
- WFI takes precedence over FENCE when both are present in the same cycle.
- Stall mask (combinational from state and inputs), first match wins. "Low N" means bits N-1..0 set.
  - WFI_SLEEP: all ones.
  - csr_excp or any ex_branch: 0.
  - hazard_stall_req: low 2.
  - dcache_stall_req, or FENCE_DRAIN with any mem_ldst: low 3.
  - FENCE_DRAIN: low 2.
  - icache_stall_req: low 1.
  - ex_stall_req: low 3.
  - Otherwise: 0.
- Bubble flush: if the stall mask is low-j with 0<j<STAGES, set flush bit j-1. If j=STAGES, no bubble.
- Redirect flush, priority csr_excp > ex_branch > dec_16bit. k = lowest-index asserted lane.
  - csr_excp: flush bits 0,1,2; issue_sel=0.
  - ex_branch[k]: bits 0,1, plus bit 2 if k<LANES-1; issue_sel=0.
  - dec_16bit[k]: bit 0, plus bit 1 if k<LANES-1; issue_sel=(k+1) mod LANES.
  - Otherwise issue_sel=0.
- flush = bubble flush OR redirect flush. Bits beyond STAGES-2 are never set.
- wfi_active = (state==WFI_SLEEP), registered; goes high the cycle after entry.
- Watchdog: increments each cycle with ctrl_stall!=0 and state!=WFI_SLEEP, saturating at all ones. It clears on any cycle with ctrl_stall=0 or in WFI_SLEEP. wdog_timeout pulses exactly once, in the cycle the counter transitions to all ones.
- Reset mid-FENCE_DRAIN or mid-WFI_SLEEP returns to RUN next cycle with no output glitch beyond the forced reset values.

Test Plan:
1. LANES=2,STAGES=5: hazard_stall_req=1 -> ctrl_stall=00011, flush=0010, issue_sel=0.
2. ex_branch=2'b01 together with icache_stall_req=1 -> ctrl_stall=00000, flush=0111, issue_sel=0. With ex_branch=2'b10 -> flush=0011.
3. dec_16bit=2'b01 -> flush=0001|0010=0011, issue_sel=1. dec_16bit=2'b10 -> flush=0001, issue_sel=0.
4. lane_fence=01, mem_ldst=01 for 3 cycles then 0 -> FENCE_DRAIN. ctrl_stall=00111, flush=0100 for 3 cycles, then 00011/0010 while ex_ldst=1, then RUN with stall 0.
5. lane_wfi=10 -> ctrl_stall=11111 from the same cycle, wfi_active=1 next cycle, watchdog held at 0. csr_wfi_clr pulse -> RUN, stall 0 that cycle, wfi_active=0 next.
6. WDOG_W=4, ex_stall_req held 20 cycles -> wdog_timeout high exactly in cycle 15 only. rst asserted mid-stall -> outputs at reset values, counter 0.
